decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Hardware RV32I instruction decoder pipeline stage. Sits between the fetch stage and the register-read/execute stage of the core.
- Accepts 32-bit instruction words with their PC over a valid/ready handshake.
- Emits registered, fully decoded control fields: register indices, sign-extended immediate, instruction class, illegal flag.
- Has a one-entry skid buffer for full throughput under backpressure, plus a flush input and a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, data/PC width; only 32 supported.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- flush  in  1  discard all held beats (branch redirect)
- in_valid  in  1  fetch beat valid
- in_ready  out  1  stage can accept beat
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of instruction
- out_valid  out  1  decoded beat valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  PC passthrough
- out_class  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 SYSTEM, 15 UNKNOWN
- out_funct3  out  3  instr[14:12]
- out_alt  out  1  instr[30] (SUB/SRA/SRAI select)
- out_rs1, out_rs2, out_rd  out  5 each  register indices (0 when unused)
- out_use_rs1, out_use_rs2, out_rd_we  out  1 each  operand/writeback enables; rd_we forced 0 when rd==0
- out_imm  out  32  sign-extended immediate
- out_illegal  out  1  encoding illegal
- illegal_cnt  out  CNT_W  saturating count of illegal beats delivered

Behaviour:
- Single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: out_valid 0, skid empty, illegal_cnt 0, in_ready 1, all out_* data fields 0.
- Handshake:
  - in_ready = !skid_full; registered, no combinational path from out_ready.
  - Transfer occurs when valid && ready.
  - Latency 1 cycle: a beat accepted at edge N is on the outputs after edge N, with out_valid=1.
- Output register loads when it is empty or out_ready=1. Source priority: skid, then the incoming beat.
- Backpressure: a beat accepted while out_valid && !out_ready goes into the skid. in_ready drops the next cycle.
- Skid drain: when out_ready=1 with the skid full, the skid moves to the output and in_ready rises the next cycle.
- Data fields hold stable while out_valid && !out_ready.
- Throughput: 1 beat/cycle when out_ready is held high.
- Flush:
  - Clears out_valid and the skid at that edge.
  - A beat presented with in_valid during flush is dropped.
  - in_ready=1 in the cycle after flush.
  - Flush overrides simultaneous acceptance and delivery.
- Immediates:
  - I: sext(i[31:20]).
  - S: sext({i[31:25], i[11:7]}).
  - B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - U: {i[31:12], 12'b0}.
  - J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - Shift-immediates: imm = {27'b0, i[24:20]}.
  - R, SYSTEM: imm = 0.
- Operand use:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - rd written by LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP.
- Illegal (out_illegal=1, all enables forced 0), any of:
  - instr[1:0] != 2'b11, or unknown opcode (class 15).
  - BRANCH with funct3 010/011.
  - LOAD with funct3 011/110/111.
  - STORE with funct3 >= 011.
  - JALR with funct3 != 0.
  - OP_IMM SLLI with funct7 != 0.
  - OP_IMM SRLI/SRAI with funct7 not in {0000000, 0100000}.
  - OP with funct7 not 0000000, or funct7 0100000 with funct3 other than 000/101.
  - SYSTEM other than exactly ECALL 0x00000073 or EBREAK 0x00100073.
- Counter: illegal_cnt increments on out_valid && out_ready && out_illegal. It saturates at all-ones. Flushed beats are not counted.
- Reset mid-operation: all state is cleared immediately and in-flight beats are lost.

Test Plan:
- Reset, then in 0xFFF18293 (addi x5,x3,-1) with PC 0x100 -> next cycle out_valid=1, class 7, rs1=3, rd=5, imm=0xFFFFFFFF, use_rs1=1, use_rs2=0, rd_we=1, illegal=0.
- Store and branch immediates:
  - 0x0020A423 (sw x2,8(x1)) -> class 6, rs1=1, rs2=2, imm=8, rd_we=0.
  - 0xFE208EE3 (beq x1,x2,-4) -> class 4, imm=0xFFFFFFFC.
- Backpressure: stream 4 beats with out_ready=0 -> beats 1-2 accepted, in_ready=0 from the 3rd cycle. Raise out_ready -> beats delivered in order, no loss or duplication, then back-to-back 1/cycle.
- Illegal: 0x402091B3 (funct7 0100000 with SLL) and 0x00000000 -> illegal=1, enables 0, illegal_cnt=2 after both are delivered. Preload the counter path to 0xFFFF to verify saturation.
- Flush with out_valid=1 and skid full -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged. A beat offered during the flush cycle is never delivered.
- Assert rst_n=0 asynchronously mid-stream -> outputs drop to reset values before the next clk edge.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: registered decoded fields, one-entry skid buffer,
// flush, and a saturating count of illegal beats delivered downstream.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       out_class,
  output logic [2:0]       out_funct3,
  output logic             out_alt,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_use_rs1,
  output logic             out_use_rs2,
  output logic             out_rd_we,
  output logic [31:0]      out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  typedef enum logic [3:0] {
    C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2, C_JALR = 4'd3, C_BR = 4'd4,
    C_LOAD = 4'd5, C_STORE = 4'd6, C_OPI = 4'd7, C_OP = 4'd8, C_SYS = 4'd9,
    C_UNK = 4'd15
  } cls_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      cls;
    logic [2:0]      f3;
    logic            alt;
    logic [4:0]      rs1, rs2, rd;
    logic            use_rs1, use_rs2, rd_we;
    logic [31:0]     imm;
    logic            ill;
  } dec_t;

  logic             skid_full_q, out_valid_q;
  logic [31:0]      skid_instr_q;
  logic [XLEN-1:0]  skid_pc_q;
  dec_t             out_q, dec;
  logic [CNT_W-1:0] cnt_q;

  logic             accept, out_load;
  logic [31:0]      i;
  logic [XLEN-1:0]  src_pc;
  cls_e             cls;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic             ill, shamt;

  assign in_ready = !skid_full_q;
  assign accept   = in_valid && in_ready;
  assign out_load = !out_valid_q || out_ready;
  // The skid always holds the older beat, so it wins the output register.
  assign i        = skid_full_q ? skid_instr_q : in_instr;
  assign src_pc   = skid_full_q ? skid_pc_q : in_pc;

  always_comb begin
    f3    = i[14:12];
    f7    = i[31:25];
    cls   = C_UNK;
    if (i[1:0] == 2'b11) begin
      case (i[6:2])
        5'b01101: cls = C_LUI;
        5'b00101: cls = C_AUIPC;
        5'b11011: cls = C_JAL;
        5'b11001: cls = C_JALR;
        5'b11000: cls = C_BR;
        5'b00000: cls = C_LOAD;
        5'b01000: cls = C_STORE;
        5'b00100: cls = C_OPI;
        5'b01100: cls = C_OP;
        5'b11100: cls = C_SYS;
        default:  cls = C_UNK;
      endcase
    end
    shamt = (cls == C_OPI) && (f3[1:0] == 2'b01);

    case (cls)
      C_UNK:   ill = 1'b1;
      C_BR:    ill = (f3[2:1] == 2'b01);
      C_LOAD:  ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      C_STORE: ill = (f3 >= 3'd3);
      C_JALR:  ill = (f3 != 3'd0);
      C_OPI:   ill = (f3 == 3'd1) ? (f7 != 7'h00)
                   : (f3 == 3'd5) ? (f7 != 7'h00 && f7 != 7'h20) : 1'b0;
      C_OP:    ill = (f7 == 7'h00) ? 1'b0
                   : (f7 == 7'h20) ? !(f3 == 3'd0 || f3 == 3'd5) : 1'b1;
      C_SYS:   ill = (i != 32'h0000_0073) && (i != 32'h0010_0073);
      default: ill = 1'b0;
    endcase

    dec         = '0;
    dec.pc      = src_pc;
    dec.cls     = cls;
    dec.f3      = f3;
    dec.alt     = i[30];
    dec.ill     = ill;
    dec.use_rs1 = !ill && (cls inside {C_JALR, C_BR, C_LOAD, C_STORE, C_OPI, C_OP});
    dec.use_rs2 = !ill && (cls inside {C_BR, C_STORE, C_OP});
    dec.rd_we   = !ill && (i[11:7] != 5'd0) &&
                  (cls inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OPI, C_OP});
    dec.rs1     = dec.use_rs1 ? i[19:15] : 5'd0;
    dec.rs2     = dec.use_rs2 ? i[24:20] : 5'd0;
    dec.rd      = dec.rd_we   ? i[11:7]  : 5'd0;

    case (cls)
      C_LUI, C_AUIPC: dec.imm = {i[31:12], 12'b0};
      C_JAL:          dec.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      C_JALR, C_LOAD: dec.imm = {{20{i[31]}}, i[31:20]};
      C_OPI:          dec.imm = shamt ? {27'b0, i[24:20]} : {{20{i[31]}}, i[31:20]};
      C_STORE:        dec.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      C_BR:           dec.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      default:        dec.imm = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full_q  <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      cnt_q        <= '0;
    end else if (flush) begin
      skid_full_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready && out_q.ill && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
      if (out_load) begin
        out_valid_q <= skid_full_q || accept;
        if (skid_full_q || accept) out_q <= dec;
        skid_full_q <= 1'b0;
      end else if (accept) begin
        skid_full_q  <= 1'b1;
        skid_instr_q <= in_instr;
        skid_pc_q    <= in_pc;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_class   = out_q.cls;
  assign out_funct3  = out_q.f3;
  assign out_alt     = out_q.alt;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_use_rs1 = out_q.use_rs1;
  assign out_use_rs2 = out_q.use_rs2;
  assign out_rd_we   = out_q.rd_we;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.ill;
  assign illegal_cnt = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps then random traffic, checked against a
// queue-of-held-beats model with an arithmetic RV32I decoder.
module tb_decode_stage;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid, out_alt, out_use_rs1, out_use_rs2, out_rd_we, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [3:0]  out_class;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [15:0] illegal_cnt;
  // Second instance with a narrow counter so saturation is reachable quickly.
  logic        s_in_ready, s_out_valid, s_alt, s_u1, s_u2, s_we, s_ill;
  logic [31:0] s_pc, s_imm;
  logic [3:0]  s_cls;
  logic [2:0]  s_f3;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [2:0]  s_cnt;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_class(out_class), .out_funct3(out_funct3), .out_alt(out_alt),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_use_rs1(out_use_rs1),
    .out_use_rs2(out_use_rs2), .out_rd_we(out_rd_we), .out_imm(out_imm),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt));

  decode_stage #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_pc), .out_class(s_cls), .out_funct3(s_f3), .out_alt(s_alt),
    .out_rs1(s_rs1), .out_rs2(s_rs2), .out_rd(s_rd), .out_use_rs1(s_u1),
    .out_use_rs2(s_u2), .out_rd_we(s_we), .out_imm(s_imm),
    .out_illegal(s_ill), .illegal_cnt(s_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc; logic [3:0] cls; logic [2:0] f3; logic alt;
    logic [4:0] rs1, rs2, rd; logic u1, u2, we; logic [31:0] imm; logic ill;
  } dec_t;
  typedef struct packed { logic [31:0] instr, pc; } beat_t;

  beat_t q[$];
  int    cnt = 0, cnt_s = 0, errors = 0, checks = 0;
  bit    acc;
  localparam logic [6:0] OPS [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                                      7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

  function automatic dec_t ref_dec(logic [31:0] i, logic [31:0] pc);
    dec_t d; int c, imm; bit ill, r1, r2, w;
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    int sx12 = i[31] ? 4096 : 0;
    imm = 0; ill = 0;
    case (i[6:0])
      7'h37: begin c = 0; imm = int'(i & 32'hFFFF_F000); end
      7'h17: begin c = 1; imm = int'(i & 32'hFFFF_F000); end
      7'h6f: begin c = 2; imm = (i[31] ? -(1 << 20) : 0) + (int'(i[19:12]) << 12)
                              + (int'(i[20]) << 11) + (int'(i[30:21]) << 1); end
      7'h67: begin c = 3; imm = int'(i[31:20]) - sx12; ill = (f3 != 0); end
      7'h63: begin c = 4; imm = -sx12 + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                              + int'(i[11:8]) * 2; ill = (f3 == 2 || f3 == 3); end
      7'h03: begin c = 5; imm = int'(i[31:20]) - sx12; ill = (f3 == 3 || f3 >= 6); end
      7'h23: begin c = 6; imm = int'({i[31:25], i[11:7]}) - sx12; ill = (f3 >= 3); end
      7'h13: begin
        c = 7;
        if (f3 == 1 || f3 == 5) imm = int'(i[24:20]); else imm = int'(i[31:20]) - sx12;
        if (f3 == 1) ill = (f7 != 0);
        if (f3 == 5) ill = !(f7 == 0 || f7 == 7'h20);
      end
      7'h33: begin c = 8; ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))); end
      7'h73: begin c = 9; ill = !(i == 32'h73 || i == 32'h0010_0073); end
      default: begin c = 15; ill = 1; end
    endcase
    r1 = !ill && (c >= 3 && c <= 8);
    r2 = !ill && (c == 4 || c == 6 || c == 8);
    w  = !ill && (c inside {0, 1, 2, 3, 5, 7, 8}) && (i[11:7] != 0);
    d.pc = pc; d.cls = 4'(c); d.f3 = f3; d.alt = i[30];
    d.rs1 = r1 ? i[19:15] : 5'd0; d.rs2 = r2 ? i[24:20] : 5'd0; d.rd = w ? i[11:7] : 5'd0;
    d.u1 = r1; d.u2 = r2; d.we = w; d.imm = 32'(imm); d.ill = ill;
    return d;
  endfunction

  function automatic logic [31:0] rnd_instr();
    int k = $urandom_range(0, 15);
    logic [31:0] r = $urandom;
    if (k < 10) r[6:0] = OPS[k];
    else if (k == 10) r = 32'h0000_0073;
    else if (k == 11) r = 32'h0010_0073;
    else if (k == 12) begin r[6:0] = 7'h33; r[31:25] = r[31] ? 7'h20 : 7'h00; end
    else if (k == 13) begin
      r[6:0] = 7'h13; r[14:12] = r[14] ? 3'd5 : 3'd1; r[31:25] = r[31] ? 7'h20 : 7'h00;
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    dec_t got;
    got = {out_pc, out_class, out_funct3, out_alt, out_rs1, out_rs2, out_rd,
           out_use_rs1, out_use_rs2, out_rd_we, out_imm, out_illegal};
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("illegal_cnt", illegal_cnt, cnt);
    chk("illegal_cnt_sat", s_cnt, cnt_s);
    if (q.size() > 0) chk("fields", got, ref_dec(q[0].instr, q[0].pc));
  endtask

  task automatic cyc();
    dec_t d;
    @(posedge clk);
    acc = rst_n && !flush && in_valid && (q.size() < 2);
    if (!rst_n) begin q.delete(); cnt = 0; cnt_s = 0; end
    else if (flush) q.delete();
    else begin
      if (q.size() > 0 && out_ready) begin
        d = ref_dec(q[0].instr, q[0].pc);
        if (d.ill) begin
          if (cnt < 65535) cnt++;
          if (cnt_s < 7) cnt_s++;
        end
        void'(q.pop_front());
      end
      if (acc) q.push_back('{in_instr, in_pc});
    end
    #1 check_all();
  endtask

  task automatic drive(bit v, logic [31:0] ins, logic [31:0] pc, bit rdy);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy;
  endtask

  initial begin
    int idx;
    logic [31:0] bp [4];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_cnt", illegal_cnt, 16'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_class", out_class, 4'd0);
    rst_n = 1'b1;

    // addi x5,x3,-1
    drive(1, 32'hFFF1_8293, 32'h100, 1); cyc();
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_class", out_class, 4'd7);
    chk("addi_rs1", out_rs1, 5'd3);
    chk("addi_rd", out_rd, 5'd5);
    chk("addi_imm", out_imm, 32'hFFFF_FFFF);
    chk("addi_en", {out_use_rs1, out_use_rs2, out_rd_we, out_illegal}, 4'b1010);
    chk("addi_pc", out_pc, 32'h100);
    // sw x2,8(x1)
    drive(1, 32'h0020_A423, 32'h104, 1); cyc();
    chk("sw_class", out_class, 4'd6);
    chk("sw_regs", {out_rs1, out_rs2}, {5'd1, 5'd2});
    chk("sw_imm", out_imm, 32'd8);
    chk("sw_we", out_rd_we, 1'b0);
    // beq x1,x2,-4
    drive(1, 32'hFE20_8EE3, 32'h108, 1); cyc();
    chk("beq_class", out_class, 4'd4);
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    drive(0, 0, 0, 1); cyc();

    // Backpressure: four beats with out_ready low, then release
    for (int k = 0; k < 4; k++) bp[k] = 32'h0000_0013 | (32'(k + 1) << 7) | (32'(k) << 20);
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1, bp[idx], 32'h200 + 32'(idx * 4), 0); cyc();
      if (acc) idx++;
      if (c >= 1) chk("bp_in_ready_low", in_ready, 1'b0);
    end
    chk("bp_accepted", idx, 2);
    for (int c = 0; c < 20 && idx < 4; c++) begin
      drive(1, bp[idx], 32'h200 + 32'(idx * 4), 1); cyc();
      if (acc) idx++;
    end
    chk("bp_all_sent", idx, 4);
    for (int k = 0; k < 8; k++) begin
      drive(1, 32'h0010_0093, 32'h300 + 32'(k * 4), 1); cyc();
      chk("b2b_accept", acc, 1'b1);
    end
    drive(0, 0, 0, 1); repeat (3) cyc();

    // Illegal encodings
    drive(1, 32'h4020_91B3, 32'h400, 1); cyc();
    chk("ill_sll_flag", {out_illegal, out_use_rs1, out_use_rs2, out_rd_we}, 4'b1000);
    drive(1, 32'h0000_0000, 32'h404, 1); cyc();
    chk("ill_zero_class", out_class, 4'd15);
    chk("ill_zero_flag", {out_illegal, out_use_rs1, out_use_rs2, out_rd_we}, 4'b1000);
    drive(0, 0, 0, 1); cyc();
    chk("ill_cnt_two", illegal_cnt, 16'd2);
    for (int k = 0; k < 10; k++) begin drive(1, 32'h0, 32'h500 + 32'(k * 4), 1); cyc(); end
    drive(0, 0, 0, 1); cyc();
    chk("sat_small", s_cnt, 3'd7);
    chk("cnt_twelve", illegal_cnt, 16'd12);

    // Flush with output and skid both full
    drive(1, 32'h0, 32'h600, 0); cyc();
    drive(1, 32'h0, 32'h604, 0); cyc();
    chk("pre_flush_full", in_ready, 1'b0);
    flush = 1'b1; drive(1, 32'h0000_0000, 32'hDEAD0, 1); cyc();
    flush = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_cnt", illegal_cnt, 16'd12);
    drive(0, 0, 0, 1);
    repeat (3) begin cyc(); chk("flush_dropped", out_valid, 1'b0); end

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom_range(0, 2) != 0);
      cyc();
    end
    flush = 1'b0;

    // Asynchronous reset mid-stream
    drive(1, 32'h0000_0000, 32'h700, 0); cyc();
    drive(1, 32'hFFF1_8293, 32'h704, 0); cyc();
    #2 rst_n = 1'b0;
    #1;
    q.delete(); cnt = 0; cnt_s = 0;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_cnt", illegal_cnt, 16'd0);
    chk("arst_fields", {out_pc, out_class, out_imm, out_rd}, '0);
    cyc();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      drive($urandom_range(0, 1) != 0, rnd_instr(), $urandom, $urandom_range(0, 1) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
